decoder_seq: RTL and testbench
==============================

Name: decoder_seq

Overview:
- Parametrised, registered successor to the fixed 5-to-32 gate-level decoder.
- Converts an index into a one-hot or thermometer output vector.
- Has an autonomous scan mode, a ring-style index sweep with a programmable step divider, used for display and column strobing in the Morse I/O path.
- Sits between control logic (index producer) and the output drivers or register-file write enables.

Parameters:
- SEL_W, 5, index width in bits.
- OUT_W, 32, number of outputs; legal range 2..2**SEL_W.
- SCAN_DIV, 1, clock cycles per scan step; legal range 1..65535.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  output enable; 0 forces outputs inactive.
- mode  in  2  operating mode: 00 DECODE, 01 THERMO, 10 SCAN, 11 HOLD.
- load  in  1  capture strobe for sel.
- sel  in  SEL_W  requested index.
- out  out  OUT_W  registered decoded vector.
- out_idx  out  SEL_W  current registered index.
- valid  out  1  out reflects an in-range index while enabled.
- wrap  out  1  one-cycle pulse when a scan step wraps from OUT_W-1 to 0.

Behaviour:
- Reset (reset_n=0 at an edge):
  - idx=0, div_cnt=0, state=IDLE.
  - out=0, out_idx=0, valid=0, wrap=0.
  - Reset wins over every other input, including mid-scan.
- Registered state: idx (SEL_W bits), div_cnt (width $clog2(SCAN_DIV+1)), state in {IDLE, DEC, SCAN, HOLD}.
- All outputs are registered; latency from load/sel to out is 1 cycle.
- State transitions, evaluated each edge:
  - en=0 -> IDLE. Out, valid and wrap are 0 next cycle. idx and div_cnt are retained.
  - en=1, mode 00 or 01 -> DEC.
  - en=1, mode 10 -> SCAN.
  - en=1, mode 11 -> HOLD.
- DEC:
  - load=1 and sel<OUT_W: idx<=sel.
  - load=1 and sel>=OUT_W: idx<=sel; next cycle out=0 and valid=0 (out-of-range).
  - load=0: idx unchanged.
  - mode 00: out[i]=(i==idx).
  - mode 01: out[i]=(i<=idx).
- Entering SCAN from any other state: idx<=0 and div_cnt<=0 on that edge; first output is out[0]=1.
- In SCAN:
  - div_cnt counts 0..SCAN_DIV-1.
  - When div_cnt==SCAN_DIV-1: div_cnt<=0 and idx<=idx+1; if idx==OUT_W-1, idx<=0 and wrap<=1 for exactly that cycle.
  - load=1 with sel<OUT_W: idx<=sel, div_cnt<=0. This has priority over the step, and no wrap pulse is generated.
  - load=1 with sel>=OUT_W: ignored.
  - Scan output is always one-hot.
- HOLD: idx, div_cnt, out and valid are frozen; load is ignored.
- Re-enable (IDLE -> DEC or HOLD): out is recomputed from the retained idx on the next cycle. IDLE -> SCAN restarts at 0.
- valid = en_registered AND (idx<OUT_W).
- out_idx always mirrors idx.
- Mode changes mid-scan take effect on the next edge; no partial vectors.
- SCAN_DIV=1: idx steps every cycle.

Decomposition:
- Package decoder_seq_pkg:
  - mode encodings MODE_DECODE=2'b00, MODE_THERMO=2'b01, MODE_SCAN=2'b10, MODE_HOLD=2'b11.
  - state enum IDLE/DEC/SCAN/HOLD.
- One combinational sub-module, decode_comb (params SEL_W, OUT_W): idx + thermo flag -> OUT_W vector, zeros when idx>=OUT_W.
- decoder_seq holds the FSM, prescaler and output registers.

Test Plan:
- Reset with reset_n=0 for 2 cycles mid-scan -> out=0, out_idx=0, valid=0, wrap=0 on the following cycle.
- DECODE, en=1, load=1, sel=5'd19 -> next cycle out=32'h0008_0000, valid=1. Then sel=5'd31 -> out=32'h8000_0000.
- THERMO, sel=5'd3 -> out=32'h0000_000F. Then sel=0 -> out=32'h0000_0001.
- OUT_W=20, SEL_W=5, DECODE, sel=5'd25 -> out=0, valid=0, out_idx=25.
- SCAN, SCAN_DIV=3, OUT_W=4:
  - idx holds each value 3 cycles: 0,1,2,3,0.
  - wrap=1 only on the cycle idx returns to 0.
  - load sel=2 mid-step -> idx=2 next cycle, div_cnt restarts.
- SCAN, then en=0 for 4 cycles, then mode=00 with no load -> out=0 while disabled; after re-enable, out is the one-hot of the retained idx.

Source files
------------

// File: rtl/decoder_seq_pkg.sv
// decoder_seq_pkg
// Shared definitions for the registered index decoder.
//   - mode encodings driven on decoder_seq.mode
//   - state_t : controller states of decoder_seq
package decoder_seq_pkg;

    localparam logic [1:0] MODE_DECODE = 2'b00;
    localparam logic [1:0] MODE_THERMO = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        SCAN = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/decoder_seq_decode.sv
// decode_comb
// Purely combinational index decoder.
//   idx    : index to decode
//   thermo : 1 = thermometer (out[i] = i <= idx), 0 = one-hot (out[i] = i == idx)
//   vec    : OUT_W-bit result, all zeros when idx is outside 0..OUT_W-1
module decode_comb #(
    parameter int SEL_W = 5,
    parameter int OUT_W = 32
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             thermo,
    output logic [OUT_W-1:0] vec
);

    localparam logic [SEL_W:0] OUT_LIM = (SEL_W+1)'(OUT_W);

    // Out-of-range indices must give an all-zero vector in both styles,
    // otherwise thermometer mode would light every output.
    always_comb begin
        vec = '0;
        if ({1'b0, idx} < OUT_LIM) begin
            for (int i = 0; i < OUT_W; i++) begin
                if (thermo)
                    vec[i] = (i <= int'(idx));
                else
                    vec[i] = (i == int'(idx));
            end
        end
    end

endmodule

// File: rtl/decoder_seq.sv
// decoder_seq
// Registered index decoder with one-hot / thermometer decode, an autonomous
// scan sweep with a programmable step divider, and a hold mode.
//   clock   : system clock, rising edge
//   reset_n : synchronous active-low reset
//   en      : output enable, 0 forces outputs inactive (index is retained)
//   mode    : 00 decode, 01 thermometer, 10 scan, 11 hold
//   load    : capture strobe for sel
//   sel     : requested index
//   out     : registered decoded vector
//   out_idx : current registered index
//   valid   : out reflects an in-range index while enabled
//   wrap    : one-cycle pulse when the scan steps from OUT_W-1 back to 0
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W    = 5,
    parameter int OUT_W    = 32,
    parameter int SCAN_DIV = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] out_idx,
    output logic             valid,
    output logic             wrap
);

    localparam int             DIV_W    = $clog2(SCAN_DIV + 1);
    localparam logic [SEL_W:0] OUT_LIM  = (SEL_W+1)'(OUT_W);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   idx, idx_nxt;
    logic [DIV_W-1:0]   div_cnt, div_nxt;
    logic [OUT_W-1:0]   out_nxt, dec_vec;
    logic               valid_nxt, wrap_nxt, thermo;

    // The decoder always looks at the index that is about to be registered,
    // which is what gives a single cycle from load/sel to out.
    assign thermo = (state_nxt == DEC) && (mode == MODE_THERMO);

    decode_comb #(
        .SEL_W(SEL_W),
        .OUT_W(OUT_W)
    ) u_decode (
        .idx   (idx_nxt),
        .thermo(thermo),
        .vec   (dec_vec)
    );

    // State and output registers; reset wins over everything, mid-scan included.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            div_cnt <= '0;
            out     <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            div_cnt <= div_nxt;
            out     <= out_nxt;
            valid   <= valid_nxt;
            wrap    <= wrap_nxt;
        end
    end

    // Next state plus index/prescaler update. Entering SCAN from anywhere
    // else restarts the sweep at 0; an in-range load inside SCAN beats the
    // divider step and never raises wrap.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        div_nxt   = div_cnt;
        wrap_nxt  = 1'b0;

        if (!en)
            state_nxt = IDLE;
        else if (mode == MODE_SCAN)
            state_nxt = SCAN;
        else if (mode == MODE_HOLD)
            state_nxt = HOLD;
        else
            state_nxt = DEC;

        case (state_nxt)
            DEC: begin
                if (load)
                    idx_nxt = sel;
            end
            SCAN: begin
                if (state != SCAN) begin
                    idx_nxt = '0;
                    div_nxt = '0;
                end else if (load && ({1'b0, sel} < OUT_LIM)) begin
                    idx_nxt = sel;
                    div_nxt = '0;
                end else if (div_cnt >= DIV_LAST) begin
                    div_nxt = '0;
                    if (idx >= LAST_IDX) begin
                        idx_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + SEL_W'(1);
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output vector and valid. HOLD freezes the last vector, except when
    // coming straight out of IDLE where the outputs were forced low and must
    // be rebuilt from the retained index.
    always_comb begin
        out_nxt   = out;
        valid_nxt = valid;
        case (state_nxt)
            IDLE: begin
                out_nxt   = '0;
                valid_nxt = 1'b0;
            end
            HOLD: begin
                if (state == IDLE) begin
                    out_nxt   = dec_vec;
                    valid_nxt = ({1'b0, idx_nxt} < OUT_LIM);
                end
            end
            default: begin
                out_nxt   = dec_vec;
                valid_nxt = ({1'b0, idx_nxt} < OUT_LIM);
            end
        endcase
    end

    assign out_idx = idx;

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq
// Self-checking bench for decoder_seq. Three instances share one stimulus
// stream: A (32 outputs, step every cycle), B (20 outputs, out-of-range
// indices) and C (4 outputs, three cycles per scan step).
module tb_decoder_seq;

    localparam int DA = 0;
    localparam int DB = 1;
    localparam int DC = 2;
    localparam int DN = 3;

    logic        clock;
    logic        reset_n;
    logic        en;
    logic [1:0]  mode;
    logic        load;
    logic [4:0]  sel;

    logic [31:0] a_out;
    logic [4:0]  a_idx;
    logic        a_valid, a_wrap;
    logic [19:0] b_out;
    logic [4:0]  b_idx;
    logic        b_valid, b_wrap;
    logic [3:0]  c_out;
    logic [4:0]  c_idx;
    logic        c_valid, c_wrap;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [1:0]  mode;
        logic        load;
        logic [4:0]  sel;
        int          dut;
        logic [31:0] exp_out;
        logic [4:0]  exp_idx;
        logic        exp_valid;
        logic        exp_wrap;
    } vec_t;

    typedef struct {
        int          dut;
        string       tag;
        logic [31:0] out;
        logic [4:0]  idx;
        logic        valid;
        logic        wrap;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    decoder_seq #(.SEL_W(5), .OUT_W(32), .SCAN_DIV(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .en(en), .mode(mode), .load(load),
        .sel(sel), .out(a_out), .out_idx(a_idx), .valid(a_valid), .wrap(a_wrap));

    decoder_seq #(.SEL_W(5), .OUT_W(20), .SCAN_DIV(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .en(en), .mode(mode), .load(load),
        .sel(sel), .out(b_out), .out_idx(b_idx), .valid(b_valid), .wrap(b_wrap));

    decoder_seq #(.SEL_W(5), .OUT_W(4), .SCAN_DIV(3)) dut_c (
        .clock(clock), .reset_n(reset_n), .en(en), .mode(mode), .load(load),
        .sel(sel), .out(c_out), .out_idx(c_idx), .valid(c_valid), .wrap(c_wrap));

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check1(input string what, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %h, want %h", what, got, want);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, queue the expected
    // result, then move to just after the rising edge that consumes it.
    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        @(negedge clock);
        reset_n = v.rst_n;
        en      = v.en;
        mode    = v.mode;
        load    = v.load;
        sel     = v.sel;
        if (v.dut != DN) begin
            e.dut   = v.dut;
            e.tag   = tag;
            e.out   = v.exp_out;
            e.idx   = v.exp_idx;
            e.valid = v.exp_valid;
            e.wrap  = v.exp_wrap;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    // Pop every pending expectation and compare against the selected instance.
    task automatic checkOutput();
        exp_t        e;
        logic [31:0] go;
        logic [4:0]  gi;
        logic        gv, gw;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                DA:      begin go = a_out;       gi = a_idx; gv = a_valid; gw = a_wrap; end
                DB:      begin go = 32'(b_out);  gi = b_idx; gv = b_valid; gw = b_wrap; end
                default: begin go = 32'(c_out);  gi = c_idx; gv = c_valid; gw = c_wrap; end
            endcase
            check1({e.tag, " out"},     go,        e.out);
            check1({e.tag, " out_idx"}, 32'(gi),   32'(e.idx));
            check1({e.tag, " valid"},   32'(gv),   32'(e.valid));
            check1({e.tag, " wrap"},    32'(gw),   32'(e.wrap));
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m, input logic l,
                        input logic [4:0] s, input int d, input logic [31:0] o,
                        input logic [4:0] i, input logic v, input logic w, input string tag);
        vec_t x;
        x = '{r, e, m, l, s, d, o, i, v, w};
        applyStimulus(x, tag);
        checkOutput();
    endtask

    initial begin
        int c_exp[14];

        reset_n = 1'b0;
        en      = 1'b0;
        mode    = 2'b00;
        load    = 1'b0;
        sel     = 5'd0;

        // rst_n en mode load sel dut out idx valid wrap
        tbl.push_back('{1'b1, 1'b1, 2'b00, 1'b1, 5'd19, DA, 32'h0008_0000, 5'd19, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b00, 1'b1, 5'd31, DA, 32'h8000_0000, 5'd31, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  DA, 32'h8000_0000, 5'd31, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b01, 1'b1, 5'd3,  DA, 32'h0000_000F, 5'd3,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b01, 1'b1, 5'd0,  DA, 32'h0000_0001, 5'd0,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b01, 1'b1, 5'd31, DA, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b00, 1'b1, 5'd25, DB, 32'h0000_0000, 5'd25, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b11, 1'b1, 5'd5,  DA, 32'h0200_0000, 5'd25, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 5'd7,  DA, 32'h0000_0000, 5'd25, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  DA, 32'h0200_0000, 5'd25, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b01, 1'b0, 5'd0,  DA, 32'h03FF_FFFF, 5'd25, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b11, 1'b1, 5'd2,  DA, 32'h03FF_FFFF, 5'd25, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 5'd0,  DA, 32'h0000_0001, 5'd0,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 5'd0,  DA, 32'h0000_0002, 5'd1,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b10, 1'b1, 5'd30, DA, 32'h4000_0000, 5'd30, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 5'd0,  DA, 32'h8000_0000, 5'd31, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 5'd0,  DA, 32'h0000_0001, 5'd0,  1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 5'd0,  DA, 32'h0000_0002, 5'd1,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b10, 1'b1, 5'd25, DB, 32'h0000_0040, 5'd6,  1'b1, 1'b0});

        $display("[TB] reset state");
        step(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, DA, 32'h0, 5'd0, 1'b0, 1'b0, "reset/A");
        step(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, DC, 32'h0, 5'd0, 1'b0, 1'b0, "reset/C");

        $display("[TB] vector table");
        for (int k = 0; k < tbl.size(); k++) begin
            applyStimulus(tbl[k], $sformatf("row%0d", k));
            checkOutput();
        end

        $display("[TB] reset held two cycles mid-scan");
        step(1'b0, 1'b1, 2'b10, 1'b1, 5'd9, DA, 32'h0, 5'd0, 1'b0, 1'b0, "midreset1");
        step(1'b0, 1'b1, 2'b10, 1'b1, 5'd9, DA, 32'h0, 5'd0, 1'b0, 1'b0, "midreset2");
        step(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, DA, 32'h1, 5'd0, 1'b1, 1'b0, "rescan0");
        step(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, DA, 32'h2, 5'd1, 1'b1, 1'b0, "rescan1");

        $display("[TB] scan with divider 3 on 4 outputs");
        step(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, DN, 32'h0, 5'd0, 1'b0, 1'b0, "");
        c_exp = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
        for (int k = 0; k < 14; k++) begin
            step(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, DC, 32'(1) << c_exp[k], 5'(c_exp[k]),
                 1'b1, (k == 12), $sformatf("scanC%0d", k));
        end
        step(1'b1, 1'b1, 2'b10, 1'b1, 5'd2, DC, 32'h4, 5'd2, 1'b1, 1'b0, "loadC0");
        step(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, DC, 32'h4, 5'd2, 1'b1, 1'b0, "loadC1");
        step(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, DC, 32'h4, 5'd2, 1'b1, 1'b0, "loadC2");
        step(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, DC, 32'h8, 5'd3, 1'b1, 1'b0, "loadC3");
        step(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, DC, 32'h8, 5'd3, 1'b1, 1'b0, "loadC4");
        step(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, DC, 32'h8, 5'd3, 1'b1, 1'b0, "loadC5");
        step(1'b1, 1'b1, 2'b10, 1'b1, 5'd0, DC, 32'h1, 5'd0, 1'b1, 1'b0, "loadwrapC");

        $display("[TB] disable mid-scan then re-enable in decode");
        step(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, DN, 32'h0, 5'd0, 1'b0, 1'b0, "");
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, DA, 32'(1) << k, 5'(k), 1'b1, 1'b0,
                 $sformatf("scanA%0d", k));
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 2'b10, 1'b0, 5'd0, DA, 32'h0, 5'd2, 1'b0, 1'b0,
                 $sformatf("offA%0d", k));
        end
        step(1'b1, 1'b1, 2'b00, 1'b0, 5'd0, DA, 32'h4, 5'd2, 1'b1, 1'b0, "reenA");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
